// File: rtl/lhz_tick_scheduler.sv
// rtl/lhz_tick_scheduler.sv - base-tick prescaler, per-channel period scheduler, round-robin job arbiter
//
// Purpose: divides clk_100MHz down to a base tick, counts each channel's period in
// base ticks and hands due channels one at a time to a shared measurement datapath
// through a start/done handshake.
// Optional feature macro: LHZ_DONE_TIMEOUT_EN (abandon a job after TIMEOUT base ticks).
//
// Ports:
//   clk_100MHz, rst_100MHz      clock, synchronous active-high reset
//   cfg_per_we/cfg_ch/cfg_period period write for one channel (0 = never fires)
//   cfg_en_we/cfg_en            channel enable mask load
//   ovr_clr                     clear all sticky overrun flags
//   done                        datapath finished the current job
//   tick_out                    1-cycle pulse per base tick
//   start/grant_id/busy         job start pulse, served channel, job outstanding
//   overrun                     sticky per-channel overrun flags
//   timeout_err                 1-cycle pulse on done timeout (tied 0 without the macro)
module lhz_tick_scheduler #(
  parameter int DIV     = 1000000,
  parameter int N_CH    = 4,
  parameter int PER_W   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic                    clk_100MHz,
  input  logic                    rst_100MHz,
  input  logic                    cfg_per_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [PER_W-1:0]        cfg_period,
  input  logic                    cfg_en_we,
  input  logic [N_CH-1:0]         cfg_en,
  input  logic                    ovr_clr,
  input  logic                    done,
  output logic                    tick_out,
  output logic                    start,
  output logic [$clog2(N_CH)-1:0] grant_id,
  output logic                    busy,
  output logic [N_CH-1:0]         overrun,
  output logic                    timeout_err
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int PRE_W = $clog2(DIV);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT} state_e;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             base_tick;
  logic             tick_q;

  logic [PER_W-1:0] per_q [N_CH];
  logic [PER_W-1:0] per_d [N_CH];
  logic [PER_W-1:0] cnt_q [N_CH];
  logic [PER_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  en_q, en_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  ovr_q, ovr_d;
  logic [N_CH-1:0]  per_wr, en_clr, active, fire;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  gid_q, gid_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic [CH_W-1:0]  win;
  logic             found;
  int               idx;
  logic             grant_clr;
  logic             to_hit;
  logic             start_q, busy_q;

  // Prescaler: base_tick marks the last count of each DIV-cycle window.
  assign base_tick = (pre_q == PRE_W'(DIV - 1));
  assign pre_d     = base_tick ? '0 : pre_q + PRE_W'(1);

  // Per-channel counters. Priority: period write, then enable clear, then tick.
  always_comb begin
    en_d   = cfg_en_we ? cfg_en : en_q;
    ovr_d  = ovr_clr ? '0 : ovr_q;
    per_wr = '0;
    en_clr = '0;
    active = '0;
    fire   = '0;
    pend_d = pend_q;
    for (int i = 0; i < N_CH; i++) begin
      per_d[i]  = per_q[i];
      cnt_d[i]  = cnt_q[i];
      per_wr[i] = cfg_per_we && (int'(cfg_ch) == i);
      en_clr[i] = cfg_en_we && en_q[i] && !cfg_en[i];
      active[i] = base_tick && en_q[i] && (per_q[i] != '0);
      if (per_wr[i]) begin
        per_d[i] = cfg_period;
        cnt_d[i] = cfg_period;
      end else if (en_clr[i]) begin
        cnt_d[i] = per_q[i];
      end else if (active[i]) begin
        if (cnt_q[i] == PER_W'(1)) begin
          cnt_d[i] = per_q[i];
          fire[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - PER_W'(1);
        end
      end
      if (grant_clr && (int'(gid_q) == i)) pend_d[i] = 1'b0;
      // A fire re-sets pend even in the cycle the grant clears it.
      if (fire[i]) begin
        pend_d[i] = 1'b1;
        if (pend_q[i]) ovr_d[i] = 1'b1;
      end
      if (en_clr[i]) pend_d[i] = 1'b0;
    end
  end

  // Round-robin search starting just above the last served channel.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && pend_q[idx]) begin
        win   = CH_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    last_d    = last_q;
    grant_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          state_d = S_GRANT;
          gid_d   = win;
        end
      end
      S_GRANT: begin
        grant_clr = 1'b1;
        last_d    = gid_q;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (done || to_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst_100MHz) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      en_q    <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      state_q <= S_IDLE;
      gid_q   <= '0;
      last_q  <= CH_W'(N_CH - 1);
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        per_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      pre_q   <= pre_d;
      tick_q  <= base_tick;
      en_q    <= en_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      start_q <= (state_d == S_GRANT);
      busy_q  <= (state_d != S_IDLE);
      for (int i = 0; i < N_CH; i++) begin
        per_q[i] <= per_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef LHZ_DONE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [TO_W-1:0] to_q, to_d;
  logic            terr_q;

  // Counts base ticks seen in WAIT; the TIMEOUT-th one expires the job.
  assign to_hit = (state_q == S_WAIT) && base_tick && (to_q == TO_W'(TIMEOUT - 1));
  assign to_d   = (state_q != S_WAIT) ? '0 :
                  (base_tick ? to_q + TO_W'(1) : to_q);

  always_ff @(posedge clk_100MHz) begin
    if (rst_100MHz) begin
      to_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      to_q   <= to_d;
      terr_q <= to_hit && !done;
    end
  end

  assign timeout_err = terr_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign tick_out = tick_q;
  assign start    = start_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;
  assign overrun  = ovr_q;

endmodule
